// File: rtl/outputs_pingpong_buffer_if.sv
// Handshake bundle for the ping-pong output buffer: row input side,
// row output side and the per-bank status flags.
interface outputs_pingpong_buffer_if #(
    parameter int COLS       = 2,
    parameter int DATA_WIDTH = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data [COLS];
    logic                         cfg_transpose;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data [COLS];
    logic                         out_last;
    logic [1:0]                   bank_full;

    // Buffer side
    modport slave (
        input  in_valid, in_data, cfg_transpose, out_ready,
        output in_ready, out_valid, out_data, out_last, bank_full
    );

    // Producer / consumer side
    modport master (
        output in_valid, in_data, cfg_transpose, out_ready,
        input  in_ready, out_valid, out_data, out_last, bank_full
    );
endinterface

// File: rtl/outputs_pingpong_buffer.sv
// Double-buffered ROWSxCOLS result collector. One bank fills row by row
// while the other, completed matrix streams out one row per cycle, either
// as written or transposed (square shapes only).
module outputs_pingpong_buffer #(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          clr,
    outputs_pingpong_buffer_if.slave      bus
);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam bit TR_OK = (ROWS == COLS);

    typedef logic signed [DATA_WIDTH-1:0] elem_t;

    elem_t          mem_q [2][ROWS][COLS];
    elem_t          mem_d [2][ROWS][COLS];
    logic           wr_bank_q, wr_bank_d;
    logic           rd_bank_q, rd_bank_d;
    logic [RW-1:0]  wr_row_q, wr_row_d;
    logic [RW-1:0]  rd_row_q, rd_row_d;
    logic [1:0]     full_q, full_d;
    logic [1:0]     tr_q, tr_d;

    logic           wr_fire, rd_fire;
    logic           wr_done, rd_done;
    elem_t          row_norm  [COLS];
    elem_t          row_trans [COLS];

    // Write and read never share a bank: writes need an empty bank,
    // reads need a full one, so both may fire in the same cycle.
    assign bus.in_ready  = !full_q[wr_bank_q];
    assign bus.out_valid = full_q[rd_bank_q];
    assign bus.bank_full = full_q;

    assign wr_fire = bus.in_valid && !full_q[wr_bank_q];
    assign rd_fire = full_q[rd_bank_q] && bus.out_ready;
    assign wr_done = wr_fire && (wr_row_q == RW'(ROWS - 1));

    // Transpose exists only for square shapes, so the final row index is
    // ROWS-1 in both readout modes.
    assign bus.out_last = full_q[rd_bank_q] && (rd_row_q == RW'(ROWS - 1));
    assign rd_done      = rd_fire && (rd_row_q == RW'(ROWS - 1));

    // Readout row: straight row of the read bank, or a column when the
    // matrix was tagged for transposed readout.
    for (genvar c = 0; c < COLS; c++) begin : g_out
        assign row_norm[c] = mem_q[rd_bank_q][rd_row_q][c];
        if (TR_OK) begin : g_tr
            assign row_trans[c] = mem_q[rd_bank_q][c][rd_row_q];
        end else begin : g_no_tr
            assign row_trans[c] = row_norm[c];
        end
        assign bus.out_data[c] = tr_q[rd_bank_q] ? row_trans[c] : row_norm[c];
    end

    // Next-state for pointers, bank flags and storage; clr wins over any
    // same-cycle transfer but leaves the storage alone.
    always_comb begin
        mem_d     = mem_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_row_d  = rd_row_q;
        full_d    = full_q;
        tr_d      = tr_q;

        if (clr) begin
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wr_row_d  = '0;
            rd_row_d  = '0;
            full_d    = 2'b00;
            tr_d      = 2'b00;
        end else begin
            if (wr_fire) begin
                for (int c = 0; c < COLS; c++) begin
                    mem_d[wr_bank_q][wr_row_q][c] = bus.in_data[c];
                end
                if (wr_done) begin
                    wr_row_d          = '0;
                    full_d[wr_bank_q] = 1'b1;
                    tr_d[wr_bank_q]   = bus.cfg_transpose && TR_OK;
                    wr_bank_d         = !wr_bank_q;
                end else begin
                    wr_row_d = wr_row_q + RW'(1);
                end
            end
            if (rd_fire) begin
                if (rd_done) begin
                    rd_row_d          = '0;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = !rd_bank_q;
                end else begin
                    rd_row_d = rd_row_q + RW'(1);
                end
            end
        end
    end

    // State registers; reset also zeroes storage so out_data reads 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        mem_q[b][r][c] <= '0;
                    end
                end
            end
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_row_q  <= '0;
            full_q    <= 2'b00;
            tr_q      <= 2'b00;
        end else begin
            mem_q     <= mem_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_row_q  <= rd_row_d;
            full_q    <= full_d;
            tr_q      <= tr_d;
        end
    end
endmodule

// File: tb/tb_outputs_pingpong_buffer.sv
// Bench for outputs_pingpong_buffer: directed scenarios plus random traffic,
// all checked against a queue-based matrix model.
module tb_outputs_pingpong_buffer;
    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int DW   = 16;

    typedef logic [COLS-1:0][DW-1:0] row_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clr = 1'b0;
    int   errs = 0;
    int   checks = 0;

    outputs_pingpong_buffer_if #(.COLS(COLS), .DATA_WIDTH(DW)) bus ();

    outputs_pingpong_buffer #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model: rows of the matrix being filled, rows awaiting readout (with
    // end-of-matrix flags) and the bank each completed matrix landed in.
    row_t part_q[$];
    row_t oq[$];
    bit   olast_q[$];
    int   bank_q[$];
    int   mcount = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic row_t mk(input int a, input int b);
        row_t r;
        r[0] = DW'(a);
        r[1] = DW'(b);
        return r;
    endfunction

    function automatic row_t rnd_row();
        row_t r;
        for (int c = 0; c < COLS; c++) r[c] = DW'($urandom);
        return r;
    endfunction

    function automatic row_t get_out();
        row_t r;
        for (int c = 0; c < COLS; c++) r[c] = bus.out_data[c];
        return r;
    endfunction

    function automatic void model_clear();
        part_q.delete();
        oq.delete();
        olast_q.delete();
        bank_q.delete();
        mcount = 0;
    endfunction

    function automatic bit m_in_ready();
        return bank_q.size() < 2;
    endfunction

    function automatic logic [1:0] m_bank_full();
        logic [1:0] b = 2'b00;
        foreach (bank_q[i]) b[bank_q[i]] = 1'b1;
        return b;
    endfunction

    task automatic check_outputs();
        chk("in_ready", 64'(bus.in_ready), 64'(m_in_ready()));
        chk("out_valid", 64'(bus.out_valid), 64'(oq.size() > 0));
        chk("bank_full", 64'(bus.bank_full), 64'(m_bank_full()));
        if (oq.size() > 0) begin
            chk("out_data", 64'(get_out()), 64'(oq[0]));
            chk("out_last", 64'(bus.out_last), 64'(olast_q[0]));
        end else begin
            chk("out_last_idle", 64'(bus.out_last), 64'd0);
        end
    endtask

    // One clock: inputs applied at the falling edge, model advanced at the
    // rising edge, outputs checked at the next falling edge.
    task automatic cyc(input bit iv, input row_t d, input bit tr, input bit ordy,
                       input bit cl, output bit wf);
        bit rf;
        row_t m [ROWS];
        bus.in_valid      = iv;
        bus.cfg_transpose = tr;
        bus.out_ready     = ordy;
        clr               = cl;
        for (int c = 0; c < COLS; c++) bus.in_data[c] = d[c];
        wf = iv && m_in_ready() && !cl;
        rf = ordy && (oq.size() > 0) && !cl;
        @(posedge clk);
        if (cl) begin
            model_clear();
        end else begin
            if (rf) begin
                void'(oq.pop_front());
                if (olast_q.pop_front()) void'(bank_q.pop_front());
            end
            if (wf) begin
                part_q.push_back(d);
                if (part_q.size() == ROWS) begin
                    for (int r = 0; r < ROWS; r++) m[r] = part_q[r];
                    part_q.delete();
                    for (int i = 0; i < ROWS; i++) begin
                        row_t o;
                        for (int c = 0; c < COLS; c++)
                            o[c] = (tr && ROWS == COLS) ? m[c][i] : m[i][c];
                        oq.push_back(o);
                        olast_q.push_back(i == ROWS - 1);
                    end
                    bank_q.push_back(mcount % 2);
                    mcount++;
                end
            end
        end
        @(negedge clk);
        clr = 1'b0;
        check_outputs();
    endtask

    initial begin
        bit   wf;
        int   n;
        row_t r5;
        bus.in_valid = 1'b0;
        bus.cfg_transpose = 1'b0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < COLS; c++) bus.in_data[c] = '0;

        // Reset state
        #12;
        model_clear();
        check_outputs();
        chk("rst_out_data", 64'(get_out()), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Normal readout
        cyc(1, mk(1, 2), 0, 1, 0, wf);
        cyc(1, mk(3, 4), 0, 1, 0, wf);
        chk("norm_r0", 64'(get_out()), 64'(mk(1, 2)));
        cyc(0, '0, 0, 1, 0, wf);
        chk("norm_r1", 64'(get_out()), 64'(mk(3, 4)));
        chk("norm_last", 64'(bus.out_last), 64'd1);
        cyc(0, '0, 0, 1, 0, wf);
        chk("norm_empty", 64'(bus.bank_full), 64'd0);

        // Transposed readout
        cyc(1, mk(1, 2), 0, 1, 0, wf);
        cyc(1, mk(3, 4), 1, 1, 0, wf);
        chk("tr_r0", 64'(get_out()), 64'(mk(1, 3)));
        cyc(0, '0, 0, 1, 0, wf);
        chk("tr_r1", 64'(get_out()), 64'(mk(2, 4)));
        chk("tr_last", 64'(bus.out_last), 64'd1);
        cyc(0, '0, 0, 1, 0, wf);

        // Backpressure: fill both banks, 5th row must wait
        for (int i = 0; i < 4; i++) cyc(1, mk(10 + i, 20 + i), 0, 0, 0, wf);
        chk("bp_full", 64'(bus.bank_full), 64'd3);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        r5 = mk(99, 98);
        cyc(1, r5, 0, 0, 0, wf);
        chk("bp_held", 64'(wf), 64'd0);
        n = 0;
        wf = 0;
        while (!wf && n < 10) begin
            n++;
            cyc(1, r5, 0, 1, 0, wf);
        end
        chk("bp_accept_cycle", 64'(n), 64'd3);
        for (int i = 0; i < 6; i++) cyc(0, '0, 0, 1, 0, wf);

        // Concurrent streaming
        for (int i = 0; i < 20; i++) begin
            cyc(1, rnd_row(), 1'($urandom), 1, 0, wf);
            chk("stream_accept", 64'(wf), 64'd1);
        end
        for (int i = 0; i < 4; i++) cyc(0, '0, 0, 1, 0, wf);

        // clr with one bank full and a partial matrix pending
        cyc(1, mk(5, 6), 0, 0, 0, wf);
        cyc(1, mk(7, 8), 0, 0, 0, wf);
        cyc(1, mk(9, 9), 0, 0, 0, wf);
        cyc(0, '0, 0, 0, 1, wf);
        chk("clr_valid", 64'(bus.out_valid), 64'd0);
        chk("clr_full", 64'(bus.bank_full), 64'd0);
        cyc(1, mk(31, 32), 0, 1, 0, wf);
        cyc(1, mk(33, 34), 0, 1, 0, wf);
        chk("clr_bank0", 64'(bus.bank_full), 64'd1);
        chk("clr_r0", 64'(get_out()), 64'(mk(31, 32)));
        for (int i = 0; i < 2; i++) cyc(0, '0, 0, 1, 0, wf);

        // Asynchronous reset mid-transfer
        cyc(1, mk(1, 1), 0, 0, 0, wf);
        cyc(1, mk(2, 2), 0, 0, 0, wf);
        cyc(1, mk(3, 3), 0, 0, 0, wf);
        bus.in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        model_clear();
        check_outputs();
        chk("arst_out_data", 64'(get_out()), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), rnd_row(), 1'($urandom),
                1'($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0), wf);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/outputs_pingpong_buffer.md
# outputs_pingpong_buffer

Double-buffered result collector for the systolic array output path. Accepts one ROWS×COLS result matrix row-by-row from the array's output edge into one bank while the previously completed matrix is streamed out of the other bank, one row per cycle, over a valid/ready interface. It generalises the single-bank output capture to rectangular shapes, backpressure on both sides, and an optional per-matrix transposed readout.

## Interface
- ROWS, 2, rows per matrix (≥2)
- COLS, 2, elements per row (≥1)
- DATA_WIDTH, 16, signed element width
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- clr  input  1  synchronous flush of pointers and bank flags
- in_valid  input  1  in_data holds a valid row
- in_ready  output  1  buffer can accept a row
- in_data  input  COLS×DATA_WIDTH (unpacked [COLS-1:0], signed)  one result row
- cfg_transpose  input  1  readout mode for the matrix whose last row is written this cycle
- out_valid  output  1  out_data holds a valid row
- out_ready  input  1  downstream accepts the row
- out_data  output  COLS×DATA_WIDTH (unpacked [COLS-1:0], signed)  one output row
- out_last  output  1  out_data is the final row of the current matrix
- bank_full  output  2  per-bank "complete, awaiting readout" flags

## Operation
- Storage: mem[2][ROWS][COLS], DATA_WIDTH signed. Registers: wr_bank, wr_row (clog2(ROWS) bits), rd_bank, rd_row, full[1:0], tr[1:0].
- in_ready = !full[wr_bank]. Write fires on in_valid && in_ready: mem[wr_bank][wr_row] <= in_data; wr_row++.
- On write with wr_row==ROWS-1: wr_row<=0, full[wr_bank]<=1, tr[wr_bank]<=cfg_transpose, wr_bank toggles.
- out_valid = full[rd_bank]. out_data combinational from mem: normal: mem[rd_bank][rd_row][c]; transpose (tr[rd_bank]=1): mem[rd_bank][c][rd_row]. out_last = out_valid && rd_row==last, last = ROWS-1 (normal) or COLS-1 (transpose).
- Read fires on out_valid && out_ready: rd_row++; on out_last: rd_row<=0, full[rd_bank]<=0, rd_bank toggles.
- Transpose legal only when ROWS==COLS; when ROWS!=COLS cfg_transpose is ignored (tr forced 0).
- Write and read never target the same bank (write needs !full, read needs full); both may fire in one cycle, including simultaneous completion of a write bank and drain of the read bank.
- in_valid while !in_ready: no write, no pointer change (stall, no loss).
- clr: wr_bank, wr_row, rd_bank, rd_row, full, tr <= 0; mem untouched; clr overrides any same-cycle write/read.
- Partial matrix (wr_row>0) stays pending indefinitely; only clr or rstn discards it.

## Timing
- Reset (rstn low, async): all pointers/flags 0, mem 0 → in_ready=1, out_valid=0, out_last=0, bank_full=2'b00, out_data=0.
- Write-to-read latency: last row written at edge N → out_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 row/cycle in, 1 row/cycle out, sustained with no bubbles when both sides are always ready.
- Both banks full → in_ready=0 until the first read of the draining matrix's last row completes; in_ready rises the cycle after that edge.
- rstn asserted mid-transfer: immediate return to reset state; de-assertion synchronous to clk upstream.

## Test plan
- Reset: rstn=0 mid-stream → in_ready=1, out_valid=0, bank_full=00, out_data={0,0}.
- Normal (ROWS=COLS=2): write rows {1,2},{3,4}, out_ready=1 → cycle after 2nd write out_data={1,2}, then {3,4} with out_last=1; bank_full returns to 00.
- Transpose: same rows with cfg_transpose=1 at the 2nd write → out {1,3} then {2,4} (out_last on 2nd).
- Backpressure: out_ready=0, write 3 matrices back-to-back → after 4 rows bank_full=11, in_ready=0, 5th row held; release out_ready → drain order matrix1 then matrix2, 5th row accepted the cycle after matrix1's last read.
- Concurrent: stream continuous matrices with out_ready=1 → every cycle one write and one read after the first 2-cycle fill, no data loss, in_ready never drops.
- clr: after 1 row of a matrix and with one bank full, pulse clr → out_valid=0, bank_full=00, next 2 written rows form a fresh matrix read out from bank 0.
